// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with per-key debounce and a first-word-fall-through event FIFO.
// Events reach the FIFO on the EMIT cycle of the qualifying sample; when the FIFO is full and not popped, the event is dropped and overflow is set.
module keypad_scan_fifo #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 3,
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPORT_RELEASE = 1
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic [NUM_COLS-1:0]                    cols,
    output logic [NUM_ROWS-1:0]                    rows,
    output logic                                   key_valid,
    input  logic                                   key_ready,
    output logic                                   key_release,
    output logic [$clog2(NUM_ROWS)-1:0]            key_row,
    output logic [$clog2(NUM_COLS)-1:0]            key_col,
    output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0]   key_code,
    output logic [$clog2(FIFO_DEPTH):0]            fifo_count,
    output logic                                   overflow,
    input  logic                                   overflow_clr
);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    localparam int NK = NUM_ROWS * NUM_COLS;
    localparam int KW = $clog2(NK);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int EW = 1 + RW + CW;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_EMIT} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DW-1:0]         r_cyc;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [NUM_COLS-1:0]   r_sync1;
    logic [NUM_COLS-1:0]   r_sync2;
    logic [NUM_COLS-1:0]   r_samp;
    logic [NK-1:0]         r_deb;
    logic [BW-1:0]         r_cnt [NK];
    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;
    logic                  r_ovf;

    logic                  w_last_cyc;
    logic                  w_last_col;
    logic                  w_samp_en;
    logic                  w_emit;
    logic [KW-1:0]         w_key;
    logic                  w_raw;
    logic                  w_diff;
    logic                  w_hit;
    logic                  w_evt;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [EW-1:0]         w_head;

    assign w_last_cyc = (r_cyc == DW'(SCAN_DIV - 1));
    assign w_last_col = (r_col == CW'(NUM_COLS - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_next = S_DRIVE;
            S_DRIVE: if (w_last_cyc) w_next = S_EMIT;
            S_EMIT:  if (w_last_col) w_next = enable ? S_DRIVE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rows      = '1;
        w_samp_en = 1'b0;
        w_emit    = 1'b0;
        if (r_state != S_IDLE) rows[r_row] = 1'b0;
        if (r_state == S_DRIVE && w_last_cyc) w_samp_en = 1'b1;
        if (r_state == S_EMIT) w_emit = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= cols;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc  <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_samp <= '1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cyc <= '0;
                    r_row <= '0;
                    r_col <= '0;
                end
                S_DRIVE: begin
                    if (w_samp_en) begin
                        r_cyc  <= '0;
                        r_col  <= '0;
                        r_samp <= r_sync2;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (w_last_col) begin
                        r_col <= '0;
                        if (enable)
                            r_row <= (r_row == RW'(NUM_ROWS - 1)) ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                default: r_cyc <= '0;
            endcase
        end
    end

    // cols are active-low: a 0 on the driven row means the key is closed
    assign w_key  = KW'(r_row) * KW'(NUM_COLS) + KW'(r_col);
    assign w_raw  = ~r_samp[r_col];
    assign w_diff = w_emit && (w_raw != r_deb[w_key]);
    assign w_hit  = w_diff && (r_cnt[w_key] == BW'(DEBOUNCE_SCANS - 1));
    assign w_evt  = w_hit && (w_raw || (REPORT_RELEASE != 0));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_deb <= '0;
            for (int k = 0; k < NK; k++) r_cnt[k] <= '0;
        end else if (w_emit) begin
            if (w_hit) begin
                r_deb[w_key] <= w_raw;
                r_cnt[w_key] <= '0;
            end else if (w_diff) begin
                r_cnt[w_key] <= r_cnt[w_key] + 1'b1;
            end else begin
                r_cnt[w_key] <= '0;
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle
    assign w_pop  = key_valid && key_ready;
    assign w_push = w_evt && ((r_count < (AW+1)'(FIFO_DEPTH)) || w_pop);
    assign w_drop = w_evt && !w_push;

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= {~w_raw, r_row, r_col};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)            r_ovf <= 1'b1;
            else if (overflow_clr) r_ovf <= 1'b0;
        end
    end

    assign w_head      = r_mem[r_rptr];
    assign key_valid   = (r_count != '0);
    assign key_release = key_valid && w_head[EW-1];
    assign key_row     = key_valid ? w_head[CW +: RW] : '0;
    assign key_col     = key_valid ? w_head[CW-1:0] : '0;
    assign key_code    = KW'(key_row) * KW'(NUM_COLS) + KW'(key_col);
    assign fifo_count  = r_count;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Randomised keypad stimulus against a frame-level debounce model; a monitor scores popped events.
module tb_keypad_scan_fifo;
    localparam int NR = 4;
    localparam int NC = 3;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FD = 4;
    localparam int NK = NR * NC;

    typedef struct packed {
        logic       rel;
        logic [1:0] row;
        logic [1:0] col;
    } ev_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          key_ready = 1'b0;
    logic          overflow_clr = 1'b0;
    logic [NC-1:0] cols;
    logic [NR-1:0] rows;
    logic          key_valid;
    logic          key_release;
    logic [1:0]    key_row;
    logic [1:0]    key_col;
    logic [3:0]    key_code;
    logic [2:0]    fifo_count;
    logic          overflow;

    keypad_scan_fifo #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .SCAN_DIV(SD), .DEBOUNCE_SCANS(DB),
        .FIFO_DEPTH(FD), .REPORT_RELEASE(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .cols(cols), .rows(rows),
        .key_valid(key_valid), .key_ready(key_ready), .key_release(key_release),
        .key_row(key_row), .key_col(key_col), .key_code(key_code),
        .fifo_count(fifo_count), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clock = ~clock;

    logic [NR-1:0][NC-1:0] key_down  = '0;
    logic [NR-1:0][NC-1:0] next_keys = '0;

    always_comb begin
        cols = '1;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (!rows[r] && key_down[r][c]) cols[c] = 1'b0;
    end

    int  errors = 0;
    int  checks = 0;
    int  n_pops = 0;
    int  frame_cnt = 0;
    int  ready_mode = 0;   // 0 low, 1 high, 2 random, 3 one-cycle pulse
    bit  stall_model = 0;
    bit  exp_ovf = 0;
    logic [NR-1:0] prev_rows = '1;
    ev_t exp_q[$];
    ev_t mon_e;

    // Model state: debounced level and the window of recent samples per key
    logic          m_deb  [NK];
    logic [DB-1:0] m_hist [NK];
    int            m_nsamp[NK];

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endfunction

    function automatic void timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        exp_ovf = 0;
        for (int k = 0; k < NK; k++) begin
            m_deb[k] = 1'b0;
            m_hist[k] = '0;
            m_nsamp[k] = 0;
        end
    endfunction

    function automatic void model_push(ev_t e);
        if (stall_model && exp_q.size() >= FD) exp_ovf = 1;
        else exp_q.push_back(e);
    endfunction

    // A key changes state once its last DB samples all disagree with its debounced level
    function automatic void model_row(int r);
        for (int c = 0; c < NC; c++) begin
            int   k;
            logic s;
            ev_t  e;
            k = r * NC + c;
            s = key_down[r][c];
            m_hist[k] = {m_hist[k][DB-2:0], s};
            if (m_nsamp[k] < DB) m_nsamp[k]++;
            if (m_nsamp[k] >= DB && m_hist[k] == {DB{~m_deb[k]}}) begin
                m_deb[k] = s;
                m_nsamp[k] = 0;
                m_hist[k] = '0;
                e.rel = ~s;
                e.row = 2'(r);
                e.col = 2'(c);
                model_push(e);
            end
        end
    endfunction

    task automatic tick();
        int r;
        @(posedge clock);
        #1;
        if (rows != prev_rows && rows != '1) begin
            r = 0;
            for (int i = 0; i < NR; i++) if (!rows[i]) r = i;
            if (r == 0) begin
                key_down = next_keys;
                frame_cnt++;
            end
            model_row(r);
        end
        prev_rows = rows;
        case (ready_mode)
            0: key_ready = 1'b0;
            1: key_ready = 1'b1;
            2: key_ready = (fifo_count >= 3'd2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            default: begin
                key_ready = 1'b1;
                ready_mode = 0;
            end
        endcase
    endtask

    task automatic wait_frames(int n);
        int t;
        int g;
        t = frame_cnt + n;
        g = 0;
        while (frame_cnt < t && g < 1000) begin
            tick();
            g++;
        end
        if (frame_cnt < t) timeout("frame_wait");
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || key_valid) && g < 400) begin
            tick();
            g++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_rows"}, rows, 15);
        chk({tag, "_valid"}, key_valid, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_code"}, key_code, 0);
        chk({tag, "_rowcol"}, {key_release, key_row, key_col}, 0);
    endtask

    always @(negedge clock) begin
        if (reset_n && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got code=%0d rel=%0d want none", key_code, key_release);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_release", key_release, mon_e.rel);
                chk("ev_row", key_row, mon_e.row);
                chk("ev_col", key_col, mon_e.col);
                chk("ev_code", key_code, mon_e.row * NC + mon_e.col);
                n_pops++;
            end
        end
    end

    initial begin
        int bad;
        int n;
        int p0;
        int g;

        model_reset();
        repeat (3) tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rows != '1 || key_valid || fifo_count != 0 || overflow) bad++;
        end
        chk("idle_hold", bad, 0);

        // Single press at (2,1) with the consumer stalled
        ready_mode = 0;
        enable = 1'b1;
        next_keys = '0;
        next_keys[2][1] = 1'b1;
        wait_frames(4);
        chk("press_valid", key_valid, 1);
        chk("press_row", key_row, 2);
        chk("press_col", key_col, 1);
        chk("press_code", key_code, 7);
        chk("press_rel", key_release, 0);
        chk("press_count", fifo_count, exp_q.size());
        ready_mode = 3;
        tick();
        tick();
        chk("pop_empty", key_valid, 0);
        ready_mode = 1;
        next_keys = '0;
        wait_frames(4);
        drain();

        // Bounce on (0,0), then a clean press and release
        ready_mode = 2;
        p0 = n_pops;
        for (int i = 0; i < 10; i++) begin
            next_keys = '0;
            next_keys[0][0] = i[0];
            wait_frames(1);
        end
        wait_frames(1);
        chk("bounce_none", n_pops - p0 + exp_q.size(), 0);
        next_keys[0][0] = 1'b1;
        wait_frames(4);
        next_keys = '0;
        wait_frames(4);
        drain();
        chk("bounce_events", n_pops - p0, 2);

        // Two keys in row 3 together
        p0 = n_pops;
        next_keys[3][0] = 1'b1;
        next_keys[3][2] = 1'b1;
        wait_frames(4);
        next_keys = '0;
        wait_frames(4);
        drain();
        chk("multi_events", n_pops - p0, 4);

        // Six events into a four-entry FIFO with no pops
        ready_mode = 0;
        tick();
        stall_model = 1;
        next_keys[0][1] = 1'b1;
        next_keys[1][2] = 1'b1;
        next_keys[3][1] = 1'b1;
        wait_frames(4);
        next_keys = '0;
        wait_frames(4);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_model_count", fifo_count, exp_q.size());
        chk("ovf_flag", overflow, exp_ovf);
        stall_model = 0;
        ready_mode = 1;
        drain();
        chk("ovf_sticky", overflow, 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_clear", overflow, 0);

        // Disable during row 1; debounce progress survives
        p0 = n_pops;
        next_keys[2][0] = 1'b1;
        wait_frames(3);
        g = 0;
        while (rows != 4'b1101 && g < 40) begin tick(); g++; end
        if (rows != 4'b1101) timeout("row1_wait");
        enable = 1'b0;
        n = 0;
        bad = 0;
        while (rows != '1 && n < 30) begin
            if (rows != 4'b1101) bad++;
            tick();
            n++;
        end
        chk("disable_latency", n, SD + NC);
        chk("disable_row_hold", bad, 0);
        repeat (40) tick();
        chk("disable_no_event", fifo_count + exp_q.size(), 0);
        enable = 1'b1;
        wait_frames(2);
        drain();
        chk("resume_event", n_pops - p0, 1);
        next_keys = '0;
        wait_frames(4);
        drain();

        // Reset in the middle of row 2's drive phase with an event queued
        ready_mode = 0;
        tick();
        stall_model = 1;
        next_keys[1][0] = 1'b1;
        wait_frames(4);
        chk("prereset_count", fifo_count, 1);
        g = 0;
        while (rows != 4'b1011 && g < 40) begin tick(); g++; end
        if (rows != 4'b1011) timeout("row2_wait");
        tick();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        stall_model = 0;
        next_keys = '0;
        tick();
        tick();
        reset_n = 1'b1;
        ready_mode = 2;

        // Random key activity
        for (int f = 0; f < 40; f++) begin
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++)
                    if ($urandom_range(0, 4) == 0) next_keys[r][c] = ~next_keys[r][c];
            wait_frames(1);
        end
        next_keys = '0;
        wait_frames(4);
        drain();
        chk("random_no_ovf", overflow, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
